fixedpt_dot_accum: RTL and testbench

//  Downstream consumer of the iterative fixed-point multiplier's val/rdy result port.

---
 rtl/fixedpt_dot_pkg.sv | 15 +
 rtl/fixedpt_sat_trunc.sv | 37 +++
 rtl/fixedpt_dot_accum.sv | 92 +++++++++
 tb/tb_fixedpt_dot_accum.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fixedpt_dot_pkg.sv
// Shared types and helpers for the fixed-point dot-product accumulator.
// Holds the FSM state encoding and the accumulator sizing rule.
package fixedpt_dot_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Headroom: $clog2(k) bits for the sum of k terms, plus one spare sign bit.
  function automatic int acc_width(input int n, input int k);
    return n + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/fixedpt_sat_trunc.sv
// Narrows a W-bit exact sum to n bits and flags values outside the n-bit range.
// Build option FIXEDPT_DOT_SAT_EN clamps the result; without it the result wraps.
module fixedpt_sat_trunc #(
  parameter int W    = 35,
  parameter int n    = 32,
  parameter bit sign = 1'b1
) (
  input  logic [W-1:0] i_acc,
  output logic [n-1:0] o_msg,
  output logic         o_ovf
);

  logic w_ovf;

  generate
    if (sign) begin : g_signed
      // In range only when every bit from n-1 upward equals the sign bit.
      assign w_ovf = ~((&i_acc[W-1:n-1]) | ~(|i_acc[W-1:n-1]));
    end else begin : g_unsigned
      assign w_ovf = |i_acc[W-1:n];
    end
  endgenerate

  assign o_ovf = w_ovf;

`ifdef FIXEDPT_DOT_SAT_EN
  localparam logic [n-1:0] MAX_VAL = sign ? {1'b0, {(n-1){1'b1}}} : {n{1'b1}};
  localparam logic [n-1:0] MIN_VAL = sign ? {1'b1, {(n-1){1'b0}}} : {n{1'b0}};

  logic w_neg;
  assign w_neg = sign & i_acc[W-1];
  assign o_msg = !w_ovf ? i_acc[n-1:0] : (w_neg ? MIN_VAL : MAX_VAL);
`else
  assign o_msg = i_acc[n-1:0];
`endif

endmodule

// File: rtl/fixedpt_dot_accum.sv
// Sums K fixed-point products into one dot product with val/rdy ports on both sides.
// FIXEDPT_DOT_SAT_EN (see fixedpt_sat_trunc) selects a saturating result instead of wrap.
module fixedpt_dot_accum
  import fixedpt_dot_pkg::*;
#(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter bit sign = 1'b1,
  parameter int K    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] recv_msg,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] send_msg,
  output logic         send_ovf
);

  localparam int W  = acc_width(n, K);
  localparam int CW = $clog2(K);

  generate
    if (K < 2 || d > n) begin : g_bad_cfg
      $error("fixedpt_dot_accum: need K >= 2 and d <= n");
    end
  endgenerate

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_count;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   w_ext;
  logic           w_recv_fire;
  logic [n-1:0]   w_msg;
  logic           w_ovf;

  assign w_ext       = {{(W-n){sign & recv_msg[n-1]}}, recv_msg};
  assign w_recv_fire = recv_val & recv_rdy;

  always_comb begin
    w_state_next = r_state;
    recv_rdy     = 1'b0;
    send_val     = 1'b0;
    case (r_state)
      ACC: begin
        recv_rdy = 1'b1;
        if (recv_val && r_count == CW'(K-1)) w_state_next = DONE;
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) w_state_next = ACC;
      end
      default: w_state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ACC;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_recv_fire) begin
      r_acc   <= r_acc + w_ext;
      r_count <= r_count + CW'(1);
    end else if (r_state == DONE && send_rdy) begin
      r_acc   <= '0;
      r_count <= '0;
    end
  end

  fixedpt_sat_trunc #(
    .W    (W),
    .n    (n),
    .sign (sign)
  ) u_sat_trunc (
    .i_acc (r_acc),
    .o_msg (w_msg),
    .o_ovf (w_ovf)
  );

  // Result is only meaningful once all K products are in.
  assign send_msg = (r_state == DONE) ? w_msg : '0;
  assign send_ovf = (r_state == DONE) ? w_ovf : 1'b0;

endmodule

// File: tb/tb_fixedpt_dot_accum.sv
// Directed bench for fixedpt_dot_accum: signed K=4 instance plus unsigned K=2 instance.
module tb_fixedpt_dot_accum;

  logic        clk = 1'b0;
  logic        reset;

  logic        recv_val, recv_rdy, send_val, send_rdy, send_ovf;
  logic [31:0] recv_msg, send_msg;

  logic        u2_recv_val, u2_recv_rdy, u2_send_val, u2_send_rdy, u2_send_ovf;
  logic [31:0] u2_recv_msg, u2_send_msg;

  int checks = 0;
  int errors = 0;

`ifdef FIXEDPT_DOT_SAT_EN
  localparam logic [31:0] EXP_POS_OVF = 32'h7FFFFFFF;
  localparam logic [31:0] EXP_NEG_OVF = 32'h80000000;
  localparam logic [31:0] EXP_U_OVF   = 32'hFFFFFFFF;
`else
  localparam logic [31:0] EXP_POS_OVF = 32'hFFFC0000;
  localparam logic [31:0] EXP_NEG_OVF = 32'h00000000;
  localparam logic [31:0] EXP_U_OVF   = 32'h00000000;
`endif

  always #5 clk = ~clk;

  fixedpt_dot_accum #(.n(32), .d(16), .sign(1'b1), .K(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .send_ovf (send_ovf)
  );

  fixedpt_dot_accum #(.n(32), .d(16), .sign(1'b0), .K(2)) u_dut_u2 (
    .clk      (clk),
    .reset    (reset),
    .recv_val (u2_recv_val),
    .recv_rdy (u2_recv_rdy),
    .recv_msg (u2_recv_msg),
    .send_val (u2_send_val),
    .send_rdy (u2_send_rdy),
    .send_msg (u2_send_msg),
    .send_ovf (u2_send_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams four products with recv_val held high, then holds send_rdy low for
  // 'hold' cycles while a poison product is offered (must not be accepted).
  task automatic run_vec(input string tag,
                         input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] p2, input logic [31:0] p3,
                         input logic [31:0] exp_msg, input logic exp_ovf,
                         input int hold);
    logic [31:0] prod [4];
    prod[0] = p0; prod[1] = p1; prod[2] = p2; prod[3] = p3;
    send_rdy = (hold == 0);
    for (int i = 0; i < 4; i++) begin
      recv_msg = prod[i];
      recv_val = 1'b1;
      check($sformatf("%s.rdy%0d", tag, i), recv_rdy, 1);
      if (i == 2) begin
        check($sformatf("%s.midval", tag), send_val, 0);
        check($sformatf("%s.midmsg", tag), send_msg, 0);
      end
      tick();
    end
    recv_msg = 32'h00100000;
    check($sformatf("%s.val", tag), send_val, 1);
    check($sformatf("%s.rdy_done", tag), recv_rdy, 0);
    check($sformatf("%s.msg", tag), send_msg, exp_msg);
    check($sformatf("%s.ovf", tag), send_ovf, exp_ovf);
    for (int h = 0; h < hold; h++) begin
      tick();
      check($sformatf("%s.hold%0d_val", tag, h), send_val, 1);
      check($sformatf("%s.hold%0d_rdy", tag, h), recv_rdy, 0);
      check($sformatf("%s.hold%0d_msg", tag, h), send_msg, exp_msg);
    end
    send_rdy = 1'b1;
    tick();
    recv_val = 1'b0;
    check($sformatf("%s.after_val", tag), send_val, 0);
    check($sformatf("%s.after_rdy", tag), recv_rdy, 1);
    $display("vector %s msg=0x%08h ovf=%0b hold=%0d", tag, exp_msg, exp_ovf, hold);
  endtask

  initial begin
    reset       = 1'b0;
    recv_val    = 1'b0;
    recv_msg    = '0;
    send_rdy    = 1'b1;
    u2_recv_val = 1'b0;
    u2_recv_msg = '0;
    u2_send_rdy = 1'b1;
    tick();
    tick();
    check("rst.rdy", recv_rdy, 1);
    check("rst.val", send_val, 0);
    check("rst.msg", send_msg, 0);
    check("rst.ovf", send_ovf, 0);
    check("rst.u2rdy", u2_recv_rdy, 1);
    reset = 1'b1;
    tick();

    run_vec("ones_a", 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
            32'h00040000, 1'b0, 0);
    run_vec("ones_b", 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
            32'h00040000, 1'b0, 0);
    run_vec("cancel", 32'hFFFE8000, 32'h00008000, 32'h00008000, 32'h00008000,
            32'h00000000, 1'b0, 0);
    run_vec("posovf", 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000,
            EXP_POS_OVF, 1'b1, 0);
    run_vec("negovf", 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
            EXP_NEG_OVF, 1'b1, 0);
    run_vec("maxexact", 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000,
            32'h7FFFFFFF, 1'b0, 0);
    run_vec("minexact", 32'hC0000000, 32'hC0000000, 32'h00000000, 32'h00000000,
            32'h80000000, 1'b0, 0);
    run_vec("stall", 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
            32'h00040000, 1'b0, 5);

    // Partial vector discarded by reset.
    recv_msg = 32'h00010000;
    recv_val = 1'b1;
    tick();
    tick();
    recv_val = 1'b0;
    reset    = 1'b0;
    #1;
    check("mrst.val_during", send_val, 0);
    check("mrst.rdy_during", recv_rdy, 1);
    tick();
    reset = 1'b1;
    tick();
    check("mrst.val_after", send_val, 0);
    check("mrst.rdy_after", recv_rdy, 1);
    $display("transaction reset mid-vector after 2 products");
    run_vec("postrst", 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
            32'h00040000, 1'b0, 0);

    // Unsigned K=2 with bubbles.
    u2_recv_msg = 32'hFFFFFFFF;
    u2_recv_val = 1'b1;
    check("u2.rdy0", u2_recv_rdy, 1);
    tick();
    u2_recv_val = 1'b0;
    for (int b = 0; b < 2; b++) begin
      check($sformatf("u2.bubble%0d_val", b), u2_send_val, 0);
      check($sformatf("u2.bubble%0d_rdy", b), u2_recv_rdy, 1);
      tick();
    end
    u2_recv_msg = 32'h00000001;
    u2_recv_val = 1'b1;
    tick();
    u2_recv_val = 1'b0;
    check("u2.val", u2_send_val, 1);
    check("u2.rdy_done", u2_recv_rdy, 0);
    check("u2.msg", u2_send_msg, EXP_U_OVF);
    check("u2.ovf", u2_send_ovf, 1);
    tick();
    check("u2.after_val", u2_send_val, 0);
    $display("vector u2 msg=0x%08h ovf=1", EXP_U_OVF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
